instr_cache: RTL and testbench
==============================

INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped cache lines (power of two).
REQ-002 Parameter WORDS, default 4, 16-bit words per line (power of two).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pc  input  16  word address of the instruction requested by the fetch stage.
REQ-006 rd_en  input  1  fetch stage requests pc this cycle.
REQ-007 flush  input  1  invalidate the whole cache.
REQ-008 instr_out  output  16  instruction word for pc; meaningful only while hit=1.
REQ-009 hit  output  1  pc present and valid, combinational from pc and array state.
REQ-010 busy  output  1  refill in progress.
REQ-011 mem_req  output  1  word read request to instruction memory.
REQ-012 mem_addr  output  16  word address of the current memory read.
REQ-013 mem_ack  input  1  memory returns mem_rdata this cycle; completes one word.
REQ-014 mem_rdata  input  16  word returned by memory.
REQ-015 miss_cnt  output  16  number of refills started since reset, saturating at 16'hFFFF.

Function
REQ-016 Address split SHALL be offset = pc[1:0], index = pc[5:2], tag = pc[15:6] for the defaults; widths derive from LINES and WORDS.
REQ-017 hit SHALL be 1 iff state=IDLE, valid[index]=1 and tag_array[index]=tag; instr_out = data[index][offset], same cycle (zero latency).
REQ-018 FSM states: IDLE, REFILL, DONE.
REQ-019 IDLE -> REFILL when rd_en=1, hit=0, flush=0; latch miss tag/index, set word counter to 0, increment miss_cnt (saturating).
REQ-020 In REFILL, mem_req SHALL be 1 and mem_addr = {miss_tag, miss_index, counter}; mem_req held stable until mem_ack.
REQ-021 On each mem_ack in REFILL, mem_rdata SHALL be written to data[miss_index][counter] and counter incremented.
REQ-022 On the ack of word WORDS-1, go to DONE; in DONE write tag_array[miss_index], set valid[miss_index] unless the refill was poisoned, go to IDLE.
REQ-023 Refill latency: a miss with mem_ack tied high yields hit=1 on the same pc exactly WORDS+2 cycles after the miss cycle.
REQ-024 busy SHALL be 1 in REFILL and DONE, 0 in IDLE; mem_req SHALL be 0 outside REFILL.
REQ-025 flush in IDLE SHALL clear all valid bits at the next edge; a simultaneous miss SHALL NOT start a refill that cycle.
REQ-026 flush in REFILL or DONE SHALL clear all valid bits and poison the refill; the refill runs to completion but the line is left invalid.
REQ-027 mem_ack outside REFILL SHALL be ignored.
REQ-028 A change of pc during REFILL SHALL NOT alter the refill in progress.

Reset
REQ-029 On rst_n=0: state=IDLE, all valid bits 0, counter 0, poison 0, miss_cnt 0, mem_req 0, mem_addr 0, busy 0, hit 0.
REQ-030 Data and tag arrays need no reset; assertion of rst_n mid-refill SHALL abandon the refill with no line validated.

Structure
REQ-031 Address-field widths, WORDS/LINES defaults and FSM state encoding SHALL live in a shared package used by instr_cache and the fetch stage.
REQ-032 Storage SHALL be one sub-module, icache_array (data + tag RAM, one write port, one async read port); valid bits stay in instr_cache.

Verification
REQ-033 Reset, rd_en=1, pc=16'h0000 -> hit=0, busy=1 next cycle, mem_addr 0,1,2,3 in order, miss_cnt=1.
REQ-034 Memory returns 16'hA000+addr, mem_ack high -> pc=16'h0002 hits with instr_out=16'hA002 at cycle 6 after the miss, no further mem_req.
REQ-035 Fill pc=16'h0004 then pc=16'h0044 (same index, different tag) -> second access misses, evicts; pc=16'h0004 misses again; miss_cnt=3.
REQ-036 mem_ack toggled 1-of-3 cycles during refill -> mem_addr holds each word until ack; data correct afterwards.
REQ-037 flush asserted during word 2 of a refill -> refill completes (4 acks), hit on that pc stays 0, new refill starts, miss_cnt increments.
REQ-038 rst_n pulsed low mid-refill -> mem_req=0 immediately, all lines miss afterwards, miss_cnt=0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and the fetch stage:
// geometry defaults, derived address-field widths and the refill FSM encoding.
package icache_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;
    localparam int DEF_OFF_W = $clog2(DEF_WORDS);
    localparam int DEF_IDX_W = $clog2(DEF_LINES);
    localparam int DEF_TAG_W = ADDR_W - DEF_IDX_W - DEF_OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } icache_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Data and tag storage for the direct-mapped instruction cache.
// One synchronous write port (data word or tag), one asynchronous read port.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS,
    parameter int IDX_W = DEF_IDX_W,
    parameter int OFF_W = DEF_OFF_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              i_data_we,
    input  logic              i_tag_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_off,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [TAG_W-1:0]  o_rd_tag
);

    logic [DATA_W-1:0] r_data [LINES][WORDS];
    logic [TAG_W-1:0]  r_tag  [LINES];

    // Contents are don't-care until their line is validated, so no reset.
    always_ff @(posedge clk) begin
        if (i_data_we) r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        if (i_tag_we)  r_tag[i_wr_idx]            <= i_wr_tag;
    end

    assign o_rd_data = r_data[i_rd_idx][i_rd_off];
    assign o_rd_tag  = r_tag[i_rd_idx];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-latency hit and a word-serial
// refill engine; valid bits, poison and miss counting live here.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | serving lookups; a qualified miss starts a refill
// ST_REFILL | requesting words 0..WORDS-1 of the missed line
// ST_DONE   | writing the tag and validating the line unless poisoned
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        rd_en,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic        hit,
    output logic        busy,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] miss_cnt
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    icache_state_t    r_state, w_next;
    logic [TAG_W-1:0] r_miss_tag;
    logic [IDX_W-1:0] r_miss_idx;
    logic [OFF_W-1:0] r_cnt;
    logic             r_poison;
    logic [LINES-1:0] r_valid;
    logic [15:0]      r_miss_cnt;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [TAG_W-1:0] w_rd_tag;
    logic [15:0]      w_rd_data;
    logic             w_hit;
    logic             w_start;
    logic             w_data_we;
    logic             w_tag_we;

    assign w_off = pc[OFF_W-1:0];
    assign w_idx = pc[OFF_W +: IDX_W];
    assign w_tag = pc[ADDR_W-1 -: TAG_W];

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .i_data_we (w_data_we),
        .i_tag_we  (w_tag_we),
        .i_wr_idx  (r_miss_idx),
        .i_wr_off  (r_cnt),
        .i_wr_data (mem_rdata),
        .i_wr_tag  (r_miss_tag),
        .i_rd_idx  (w_idx),
        .i_rd_off  (w_off),
        .o_rd_data (w_rd_data),
        .o_rd_tag  (w_rd_tag)
    );

    assign w_hit = (r_state == ST_IDLE) && r_valid[w_idx] && (w_rd_tag == w_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_data_we = 1'b0;
        w_tag_we  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rd_en && !w_hit && !flush) begin
                    w_start = 1'b1;
                    w_next  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    w_data_we = 1'b1;
                    if (r_cnt == LAST_WORD) w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_tag_we = 1'b1;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            r_cnt      <= '0;
            r_poison   <= 1'b0;
            r_valid    <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_start) begin
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
                r_cnt      <= '0;
                r_miss_cnt <= sat_inc16(r_miss_cnt);
            end else if (w_data_we) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Poison only matters until DONE consumes it; clear it there.
            if (r_state == ST_DONE)
                r_poison <= 1'b0;
            else if (r_state == ST_REFILL && flush)
                r_poison <= 1'b1;

            if (flush)
                r_valid <= '0;
            else if (w_tag_we && !r_poison)
                r_valid[r_miss_idx] <= 1'b1;
        end
    end

    assign hit       = w_hit;
    assign instr_out = w_rd_data;
    assign busy      = (r_state != ST_IDLE);
    assign mem_req   = (r_state == ST_REFILL);
    assign mem_addr  = mem_req ? {r_miss_tag, r_miss_idx, r_cnt} : 16'h0000;
    assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: lookup vector table plus hand-written
// sequences for refill latency, eviction, slow memory, flush and reset.
module tb_instr_cache;

    localparam int WORDS = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        rd_en;
    logic        flush;
    logic [15:0] instr_out;
    logic        hit;
    logic        busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] miss_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_miss = 0;

    typedef struct {
        logic [15:0] pc;
        logic        exp_hit;
        logic [15:0] exp_instr;
    } lookup_t;

    lookup_t tbl [12];

    instr_cache #(.LINES(16), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .rd_en     (rd_en),
        .flush     (flush),
        .instr_out (instr_out),
        .hit       (hit),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    assign mem_rdata = 16'hA000 + mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic lookup(input string name, input logic [15:0] a, input logic eh, input logic [15:0] ei);
        pc = a;
        rd_en = 1'b0;
        #2;
        chk(name, {31'd0, hit}, {31'd0, eh});
        if (eh) chk({name, "_instr"}, {16'd0, instr_out}, {16'd0, ei});
    endtask

    // mode 0: ack every cycle; mode 1: ack one cycle in three.
    // flush_at >= 0 pulses flush while that word index is being requested.
    task automatic do_refill(input logic [15:0] a, input int mode, input int flush_at);
        int k, bad, n;
        logic [15:0] base;
        base = {a[15:2], 2'b00};
        pc = a;
        rd_en = 1'b1;
        mem_ack = (mode == 0);
        cyc();
        rd_en = 1'b0;
        exp_miss++;
        chk("refill_miss_cnt", {16'd0, miss_cnt}, exp_miss);
        k = 0; bad = 0; n = 0;
        while (busy && n < 300) begin
            if (mem_req) begin
                mem_ack = (mode == 0) || (n % 3 == 2);
                flush = (k == flush_at);
                if (mem_addr !== base + 16'(k)) bad++;
                if (mem_ack) k++;
            end else begin
                flush = 1'b0;
            end
            n++;
            cyc();
        end
        flush = 1'b0;
        mem_ack = 1'b0;
        chk("refill_addr_errors", bad, 0);
        chk("refill_words_acked", k, WORDS);
        chk("refill_terminated", {31'd0, n < 300}, 1);
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; rd_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        repeat (3) cyc();
        chk("rst_hit", {31'd0, hit}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 0);
        rst_n = 1'b1;
        cyc();

        // First miss with memory acking every cycle: exact latency.
        pc = 16'h0000; rd_en = 1'b1; mem_ack = 1'b1;
        #2;
        chk("first_miss_hit", {31'd0, hit}, 0);
        cyc();
        rd_en = 1'b0;
        exp_miss = 1;
        chk("first_busy", {31'd0, busy}, 1);
        chk("first_miss_cnt", {16'd0, miss_cnt}, 1);
        for (int i = 0; i < WORDS; i++) begin
            chk("first_mem_req", {31'd0, mem_req}, 1);
            chk("first_mem_addr", {16'd0, mem_addr}, i);
            if (i == WORDS - 1) pc = 16'h0002;
            cyc();
        end
        chk("done_mem_req", {31'd0, mem_req}, 0);
        chk("done_busy", {31'd0, busy}, 1);
        chk("done_no_hit_yet", {31'd0, hit}, 0);
        cyc();
        chk("latency_hit", {31'd0, hit}, 1);
        chk("latency_instr", {16'd0, instr_out}, 16'hA002);
        chk("idle_busy", {31'd0, busy}, 0);
        rd_en = 1'b1;
        cyc();
        cyc();
        rd_en = 1'b0;
        chk("hit_no_mem_req", {31'd0, mem_req}, 0);
        chk("hit_no_miss_cnt", {16'd0, miss_cnt}, 1);
        mem_ack = 1'b0;

        // Conflict eviction on index 1.
        do_refill(16'h0004, 0, -1);
        lookup("conflict_pre", 16'h0044, 1'b0, 16'h0);
        do_refill(16'h0044, 0, -1);
        lookup("evicted_0004", 16'h0004, 1'b0, 16'h0);
        lookup("new_0045", 16'h0045, 1'b1, 16'hA045);
        do_refill(16'h0004, 0, -1);

        // Slow memory: address must hold until each ack.
        do_refill(16'h1238, 1, -1);

        tbl[0]  = '{16'h0000, 1'b1, 16'hA000};
        tbl[1]  = '{16'h0003, 1'b1, 16'hA003};
        tbl[2]  = '{16'h0005, 1'b1, 16'hA005};
        tbl[3]  = '{16'h0007, 1'b1, 16'hA007};
        tbl[4]  = '{16'h0044, 1'b0, 16'h0000};
        tbl[5]  = '{16'h0046, 1'b0, 16'h0000};
        tbl[6]  = '{16'h0008, 1'b0, 16'h0000};
        tbl[7]  = '{16'h0040, 1'b0, 16'h0000};
        tbl[8]  = '{16'hFFC0, 1'b0, 16'h0000};
        tbl[9]  = '{16'h1238, 1'b1, 16'hB238};
        tbl[10] = '{16'h1239, 1'b1, 16'hB239};
        tbl[11] = '{16'h123B, 1'b1, 16'hB23B};
        mem_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            lookup($sformatf("table_%0d", i), tbl[i].pc, tbl[i].exp_hit, tbl[i].exp_instr);
            cyc();
        end
        mem_ack = 1'b0;
        chk("table_miss_cnt", {16'd0, miss_cnt}, exp_miss);

        // Flush during word 2: refill completes but line stays invalid.
        do_refill(16'h0010, 0, 2);
        lookup("poisoned_0010", 16'h0010, 1'b0, 16'h0);
        lookup("flushed_0000", 16'h0000, 1'b0, 16'h0);
        do_refill(16'h0010, 0, -1);
        lookup("refilled_0012", 16'h0012, 1'b1, 16'hA012);

        // Flush in IDLE with a simultaneous miss: no refill.
        pc = 16'h0020; rd_en = 1'b1; flush = 1'b1;
        cyc();
        rd_en = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'd0, busy}, 0);
        chk("flush_idle_miss_cnt", {16'd0, miss_cnt}, exp_miss);
        lookup("flush_idle_0010", 16'h0010, 1'b0, 16'h0);

        // Reset in the middle of a refill.
        pc = 16'h0080; rd_en = 1'b1; mem_ack = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 1);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_miss_cnt", {16'd0, miss_cnt}, 0);
        cyc();
        rst_n = 1'b1;
        mem_ack = 1'b0;
        exp_miss = 0;
        lookup("post_rst_0080", 16'h0080, 1'b0, 16'h0);
        lookup("post_rst_0012", 16'h0012, 1'b0, 16'h0);
        cyc();
        do_refill(16'h0080, 0, -1);
        lookup("post_rst_refill", 16'h0083, 1'b1, 16'hA083);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
